// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   state_t        : FSM state encodings (ST_IDLE / ST_SHIFT / ST_DONE)
//   BCD_DIGIT_MAX  : largest legal BCD digit value
//   DD_ADJ_THRESH  : reverse double-dabble correction threshold
//   DD_ADJ_VAL     : amount subtracted from a digit at/above the threshold
//   dd_adjust()    : single-digit correction helper
package bcd_to_binary_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] DD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] DD_ADJ_VAL    = 4'd3;

  // After a right shift a digit that received the bit from the digit above
  // carries a weight of 8 that really means 5 (10/2); subtracting 3 fixes it.
  function automatic logic [3:0] dd_adjust(input logic [3:0] d);
    return (d >= DD_ADJ_THRESH) ? (d - DD_ADJ_VAL) : d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction (combinational).
// Ports:
//   d : in  4  BCD digit taken right after the shift
//   q : out 4  corrected digit (d >= 8 ? d - 3 : d)
module bcd_digit_adj
  import bcd_to_binary_seq_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = dd_adjust(d);

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one
// shift/correct step per clock with a start/busy/done handshake.
// Ports:
//   clk       : in  1         rising-edge clock
//   rst_n     : in  1         asynchronous active-low reset
//   start     : in  1         conversion request, sampled in IDLE or DONE
//   bcd       : in  4*DIGITS  packed BCD operand, digit 0 in [3:0]
//   busy      : out 1         conversion in progress
//   done      : out 1         one-cycle pulse, result/flags valid
//   bin       : out W         binary result, value mod 2^W
//   err_digit : out 1         some input digit was > 9 (bin forced to 0)
//   ovf       : out 1         value did not fit in W bits
module bcd_to_binary_seq
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int W      = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        bin,
  output logic                err_digit,
  output logic                ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + W;
  localparam int CW = $clog2(W + 1);

  state_t          state_reg, state_next;
  logic [SW-1:0]   shreg_reg;
  logic [SW-1:0]   shifted;
  logic [SW-1:0]   shreg_adj;
  logic [BW-1:0]   adj_bcd;
  logic [CW-1:0]   cnt_reg;
  logic [DIGITS-1:0] digit_bad;
  logic            bad_any;
  logic            last_shift;
  logic [W-1:0]    bin_reg;
  logic            err_reg;
  logic            ovf_reg;

  // Shift the whole {bcd, bin} register right, then correct each BCD digit.
  assign shifted = shreg_reg >> 1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_adj u_adj (
        .d (shifted[W + 4*gi +: 4]),
        .q (adj_bcd[4*gi +: 4])
      );
      assign digit_bad[gi] = (bcd[4*gi +: 4] > BCD_DIGIT_MAX);
    end
  endgenerate

  assign shreg_adj  = {adj_bcd, shifted[W-1:0]};
  assign bad_any    = |digit_bad;
  assign last_shift = (cnt_reg == CW'(W - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = bad_any ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_shift) state_next = ST_DONE;
      end
      ST_DONE: begin
        // A start on the done cycle is taken immediately (no idle bubble).
        if (start) state_next = bad_any ? ST_DONE : ST_SHIFT;
        else       state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: shift register, step counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
      bin_reg   <= '0;
      err_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (bad_any) begin
              // Invalid operand: report directly, no shifting.
              bin_reg <= '0;
              err_reg <= 1'b1;
              ovf_reg <= 1'b0;
            end else begin
              shreg_reg <= {bcd, {W{1'b0}}};
              cnt_reg   <= '0;
              err_reg   <= 1'b0;
              ovf_reg   <= 1'b0;
            end
          end
        end
        ST_SHIFT: begin
          shreg_reg <= shreg_adj;
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_shift) begin
            // Any residue left in the BCD part means the value needs > W bits.
            bin_reg <= shreg_adj[W-1:0];
            ovf_reg <= |shreg_adj[SW-1:W];
          end
        end
        default: begin
          shreg_reg <= shreg_reg;
        end
      endcase
    end
  end

  assign busy      = (state_reg == ST_SHIFT);
  assign done      = (state_reg == ST_DONE);
  assign bin       = bin_reg;
  assign err_digit = err_reg;
  assign ovf       = ovf_reg;

endmodule
